// File: rtl/manchester_frame_sync_pkg.sv
// Shared state and chip-slice encodings for the Manchester frame synchroniser.
package manchester_frame_sync_pkg;

  typedef enum logic [1:0] {
    ST_HUNT     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_SFD      = 2'd2,
    ST_DATA     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    ONE   = 2'b01,
    ERASE = 2'b10
  } chip_t;

  localparam int SFD_TIMEOUT_BITS = 16;

endpackage

// File: rtl/manchester_frame_sync_pair_dec.sv
// Chip slicer and Manchester pair decoder: (1,0) -> bit 1, (0,1) -> bit 0, else violation.
module manchester_pair_dec
  import manchester_frame_sync_pkg::*;
#(
  parameter int word_width = 2
) (
  input  logic signed [word_width-1:0] chip_first,
  input  logic signed [word_width-1:0] chip_second,
  output logic                         dec_bit,
  output logic                         violation
);

  function automatic chip_t slice(input logic signed [word_width-1:0] s);
    if (s == '0) return ERASE;
    return s[word_width-1] ? ZERO : ONE;
  endfunction

  chip_t first_c;
  chip_t second_c;

  always_comb begin
    first_c   = slice(chip_first);
    second_c  = slice(chip_second);
    dec_bit   = (first_c == ONE);
    violation = (first_c == ERASE) || (second_c == ERASE) || (first_c == second_c);
  end

endmodule

// File: rtl/manchester_frame_sync.sv
// Manchester preamble/SFD frame synchroniser and byte assembler.
// Optional MANCHESTER_ERR_CNT_EN adds a saturating 16-bit violation counter output.
module manchester_frame_sync
  import manchester_frame_sync_pkg::*;
#(
  parameter int         word_width    = 2,
  parameter int         PREAMBLE_BITS = 8,
  parameter logic [7:0] SFD           = 8'hD5,
  parameter int         FRAME_BYTES   = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  input  logic signed [word_width-1:0] i_data,
  input  logic signed [word_width-1:0] i_data_d1,
  output logic [7:0]                   o_byte,
  output logic                         o_byte_valid,
  output logic                         o_frame_done,
  output logic                         o_err,
  output logic                         o_locked
`ifdef MANCHESTER_ERR_CNT_EN
  ,
  output logic [15:0]                  o_err_cnt
`endif
);

  localparam int PB_W  = $clog2(PREAMBLE_BITS + 1);
  localparam int CNT_W = (PB_W > 5) ? PB_W : 5;
  localparam int BC_W  = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

  state_t           state, state_nx;
  logic             phase, phase_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [BC_W-1:0]  byte_cnt, byte_cnt_nx;
  logic             prev_bit, prev_nx;
  logic [7:0]       sr, sr_nx, shifted;
  logic [7:0]       byte_nx;
  logic             bv_nx, fd_nx, err_nx;
  logic             eval, go_hunt;
  logic             dec_bit, violation;

  manchester_pair_dec #(.word_width(word_width)) u_pair_dec (
    .chip_first (i_data_d1),
    .chip_second(i_data),
    .dec_bit    (dec_bit),
    .violation  (violation)
  );

  // HUNT checks every valid chip; once aligned only every second one closes a pair.
  always_comb begin
    state_nx    = state;
    phase_nx    = phase;
    cnt_nx      = cnt;
    byte_cnt_nx = byte_cnt;
    prev_nx     = prev_bit;
    sr_nx       = sr;
    byte_nx     = o_byte;
    bv_nx       = 1'b0;
    fd_nx       = 1'b0;
    err_nx      = 1'b0;
    go_hunt     = 1'b0;
    shifted     = {dec_bit, sr[7:1]};
    eval        = i_valid && ((state == ST_HUNT) || phase);

    if (i_valid && (state != ST_HUNT)) phase_nx = ~phase;

    if (eval) begin
      case (state)
        ST_HUNT: begin
          if (!violation) begin
            state_nx = ST_PREAMBLE;
            cnt_nx   = CNT_W'(1);
            prev_nx  = dec_bit;
            phase_nx = 1'b0;
          end
        end
        ST_PREAMBLE: begin
          if (violation || (dec_bit == prev_bit)) begin
            go_hunt = 1'b1;
          end else begin
            prev_nx = dec_bit;
            if (cnt == CNT_W'(PREAMBLE_BITS - 1)) begin
              state_nx = ST_SFD;
              cnt_nx   = '0;
              sr_nx    = '0;
            end else begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end
        end
        ST_SFD: begin
          if (violation) begin
            go_hunt = 1'b1;
          end else begin
            sr_nx = shifted;
            if (shifted == SFD) begin
              state_nx = ST_DATA;
              cnt_nx   = '0;
            end else if (cnt == CNT_W'(SFD_TIMEOUT_BITS - 1)) begin
              go_hunt = 1'b1;
            end else begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          if (violation) begin
            err_nx  = 1'b1;
            go_hunt = 1'b1;
          end else begin
            sr_nx = shifted;
            if (cnt == CNT_W'(7)) begin
              byte_nx = shifted;
              bv_nx   = 1'b1;
              cnt_nx  = '0;
              if (byte_cnt == BC_W'(FRAME_BYTES - 1)) begin
                fd_nx   = 1'b1;
                go_hunt = 1'b1;
              end else begin
                byte_cnt_nx = byte_cnt + BC_W'(1);
              end
            end else begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end

    if (go_hunt) begin
      state_nx    = ST_HUNT;
      phase_nx    = 1'b0;
      cnt_nx      = '0;
      byte_cnt_nx = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_HUNT;
      phase        <= 1'b0;
      cnt          <= '0;
      byte_cnt     <= '0;
      o_byte       <= 8'h00;
      o_byte_valid <= 1'b0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state        <= state_nx;
      phase        <= phase_nx;
      cnt          <= cnt_nx;
      byte_cnt     <= byte_cnt_nx;
      o_byte       <= byte_nx;
      o_byte_valid <= bv_nx;
      o_frame_done <= fd_nx;
      o_err        <= err_nx;
    end
  end

  // Shift register and last bit are always rewritten before use, so they carry no reset.
  always_ff @(posedge i_clk) begin
    sr       <= sr_nx;
    prev_bit <= prev_nx;
  end

  assign o_locked = (state == ST_SFD) || (state == ST_DATA);

`ifdef MANCHESTER_ERR_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                             o_err_cnt <= '0;
    else if (err_nx && (o_err_cnt != 16'hFFFF)) o_err_cnt <= o_err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_manchester_frame_sync.sv
// Bench for manchester_frame_sync: scenario table, hand sequences and random frames vs a bit-list model.
module tb_manchester_frame_sync;

  localparam int         W  = 2;
  localparam int         PB = 8;
  localparam int         FB = 4;
  localparam logic [7:0] SFD_V = 8'hD5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                valid = 1'b0;
  logic signed [W-1:0] data = '0;
  logic signed [W-1:0] data_d1 = '0;
  logic [7:0]          byte_o;
  logic                byte_valid, frame_done, err, locked;
`ifdef MANCHESTER_ERR_CNT_EN
  logic [15:0]         err_cnt;
`endif

  manchester_frame_sync #(
    .word_width(W), .PREAMBLE_BITS(PB), .SFD(SFD_V), .FRAME_BYTES(FB)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .i_data_d1(data_d1),
    .o_byte(byte_o), .o_byte_valid(byte_valid), .o_frame_done(frame_done),
    .o_err(err), .o_locked(locked)
`ifdef MANCHESTER_ERR_CNT_EN
    , .o_err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference model: decoded bits since alignment kept as a list; frame phase derived from its length.
  bit         m_aligned, m_half, m_sfd_found;
  int         m_data_start;
  bit         m_q[$];
  logic [7:0] exp_byte;
  bit         exp_bv, exp_fd, exp_err;
  int         m_err_cnt;

  function automatic void drop();
    m_aligned = 0; m_half = 0; m_sfd_found = 0; m_q.delete();
  endfunction

  function automatic void model_reset();
    drop();
    exp_byte = 8'h00; exp_bv = 0; exp_fd = 0; exp_err = 0; m_err_cnt = 0;
  endfunction

  function automatic bit m_locked();
    return m_aligned && (m_q.size() >= PB);
  endfunction

  function automatic int slice(input int s);
    if (s > 0) return 1;
    if (s < 0) return 0;
    return -1;
  endfunction

  function automatic void model_step(input int d1, input int d0);
    int a, b, n, d, idx;
    bit viol, bt;
    logic [7:0] v;
    a = slice(d1); b = slice(d0);
    viol = (a < 0) || (b < 0) || (a == b);
    bt = (a == 1);
    if (m_aligned) begin
      if (!m_half) begin m_half = 1; return; end
      m_half = 0;
    end else begin
      if (!viol) begin drop(); m_aligned = 1; m_q.push_back(bt); end
      return;
    end
    if (viol) begin
      if (m_sfd_found) begin
        exp_err = 1;
        if (m_err_cnt < 65535) m_err_cnt++;
      end
      drop();
      return;
    end
    n = m_q.size();
    m_q.push_back(bt);
    if (n < PB) begin
      if (bt == m_q[n-1]) drop();
      return;
    end
    if (!m_sfd_found) begin
      for (int i = 0; i < 8; i++) begin
        idx = m_q.size() - 8 + i;
        v[i] = (idx >= PB) ? m_q[idx] : 1'b0;
      end
      if (v == SFD_V) begin
        m_sfd_found = 1; m_data_start = m_q.size();
      end else if (m_q.size() - PB == 16) drop();
      return;
    end
    d = m_q.size() - m_data_start;
    if (d % 8 == 0) begin
      for (int i = 0; i < 8; i++) v[i] = m_q[m_data_start + d - 8 + i];
      exp_byte = v; exp_bv = 1;
      if (d / 8 == FB) begin exp_fd = 1; drop(); end
    end
  endfunction

  // Driver / per-cycle checker
  bit   chk_en = 0;
  bit   pend_v = 0;
  int   pend_d1, pend_d0;
  int   prev = 0;
  logic [7:0] obs_bytes[$];
  int   obs_done, obs_err;
  bit   obs_locked_seen;

  task automatic obs_clear();
    obs_bytes.delete(); obs_done = 0; obs_err = 0; obs_locked_seen = 0;
  endtask

  task automatic check_outputs();
    cmp($sformatf("cycle@%0t byte/bv/fd/err/lk", $time),
        {byte_o, byte_valid, frame_done, err, locked},
        {exp_byte, exp_bv, exp_fd, exp_err, m_locked()});
`ifdef MANCHESTER_ERR_CNT_EN
    cmp($sformatf("cycle@%0t err_cnt", $time), err_cnt, m_err_cnt);
`endif
    if (byte_valid) obs_bytes.push_back(byte_o);
    if (frame_done) obs_done++;
    if (err) obs_err++;
    if (locked) obs_locked_seen = 1;
  endtask

  task automatic drive(input bit v, input int s);
    int r;
    @(negedge clk);
    exp_bv = 0; exp_fd = 0; exp_err = 0;
    if (pend_v) model_step(pend_d1, pend_d0);
    if (chk_en) check_outputs();
    r = $urandom;
    valid   = v;
    data    = v ? s[W-1:0] : r[W-1:0];
    data_d1 = prev[W-1:0];
    pend_v = v; pend_d1 = prev; pend_d0 = s;
    if (v) prev = s;
  endtask

  int chips[$];

  task automatic push_bit(input bit b, input bit bad);
    int ng;
    ng = -int'($urandom_range(1, 2));
    if (bad)    begin chips.push_back(1);  chips.push_back(1);  end
    else if (b) begin chips.push_back(1);  chips.push_back(ng); end
    else        begin chips.push_back(ng); chips.push_back(1);  end
  endtask

  task automatic send_frame(input logic [31:0] pay, input int nbytes, input logic [7:0] sfd,
                            input int fb, input int fbit, input bit slip, input int gap_at,
                            input bit rnd, input int stop_at, input bit noise);
    chips.delete();
    if (noise) repeat ($urandom_range(0, 4)) chips.push_back(int'($urandom_range(0, 3)) - 2);
    chips.push_back(0); chips.push_back(0);
    if (slip) chips.push_back(1);
    for (int i = 0; i < PB; i++) push_bit(i % 2 == 0, 0);
    for (int i = 0; i < 8; i++) push_bit(sfd[i], 0);
    for (int k = 0; k < nbytes; k++)
      for (int i = 0; i < 8; i++) push_bit(pay[8*k+i], (k == fb) && (i == fbit));
    chips.push_back(0); chips.push_back(0);
    for (int c = 0; c < chips.size(); c++) begin
      if (stop_at >= 0 && c == stop_at) return;
      if (c == gap_at) repeat (3) drive(0, 0);
      if (rnd && $urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) drive(0, 0);
      drive(1, chips[c]);
    end
  endtask

  typedef struct {
    logic [31:0] pay;
    int          fb;
    int          fbit;
    bit          slip;
    int          gap_at;
    int          exp_n;
    logic [31:0] exp_b;
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{pay:32'hFF003CA5, fb:-1, fbit:0, slip:0, gap_at:-1, exp_n:4, exp_b:32'hFF003CA5, exp_done:1, exp_err:0};
    tbl[1] = '{pay:32'hFF003CA5, fb:1,  fbit:3, slip:0, gap_at:-1, exp_n:1, exp_b:32'h000000A5, exp_done:0, exp_err:1};
    tbl[2] = '{pay:32'hFF003CA5, fb:-1, fbit:0, slip:1, gap_at:-1, exp_n:4, exp_b:32'hFF003CA5, exp_done:1, exp_err:0};
    tbl[3] = '{pay:32'hFF003CA5, fb:-1, fbit:0, slip:0, gap_at:71, exp_n:4, exp_b:32'hFF003CA5, exp_done:1, exp_err:0};
    tbl[4] = '{pay:32'hFF003CA5, fb:0,  fbit:7, slip:0, gap_at:-1, exp_n:0, exp_b:32'h00000000, exp_done:0, exp_err:1};
    tbl[5] = '{pay:32'h78563412, fb:-1, fbit:0, slip:0, gap_at:-1, exp_n:4, exp_b:32'h78563412, exp_done:1, exp_err:0};

    model_reset();
    obs_clear();
    repeat (3) drive(0, 0);
    #1;
    cmp("reset_outputs", {byte_o, byte_valid, frame_done, err, locked}, 12'h000);
`ifdef MANCHESTER_ERR_CNT_EN
    cmp("reset_err_cnt", err_cnt, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1;

    for (int i = 0; i < 6; i++) begin
      obs_clear();
      send_frame(tbl[i].pay, FB, SFD_V, tbl[i].fb, tbl[i].fbit, tbl[i].slip, tbl[i].gap_at, 0, -1, 0);
      cmp($sformatf("tbl%0d_nbytes", i), obs_bytes.size(), tbl[i].exp_n);
      for (int k = 0; k < tbl[i].exp_n && k < obs_bytes.size(); k++)
        cmp($sformatf("tbl%0d_byte%0d", i, k), obs_bytes[k], tbl[i].exp_b[8*k +: 8]);
      cmp($sformatf("tbl%0d_done", i), obs_done, tbl[i].exp_done);
      cmp($sformatf("tbl%0d_err", i), obs_err, tbl[i].exp_err);
      cmp($sformatf("tbl%0d_locked_end", i), locked, 1'b0);
`ifdef MANCHESTER_ERR_CNT_EN
      if (i == 1) cmp("err_cnt_after_fault", err_cnt, 16'd1);
`endif
    end

    // SFD never found: 16 bits of 0x55 after the preamble
    obs_clear();
    send_frame(32'h00000055, 1, 8'h55, -1, 0, 0, -1, 0, -1, 0);
    cmp("sfd_timeout_locked_seen", obs_locked_seen, 1'b1);
    cmp("sfd_timeout_locked_end", locked, 1'b0);
    cmp("sfd_timeout_err", obs_err, 0);
    cmp("sfd_timeout_bytes", obs_bytes.size(), 0);

    // Reset in the middle of the third byte, then a clean frame
    obs_clear();
    send_frame(32'hFF003CA5, FB, SFD_V, -1, 0, 0, -1, 0, 71, 0);
    cmp("pre_reset_locked", locked, 1'b1);
    cmp("pre_reset_byte", byte_o, 8'h3C);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_reset_outputs", {byte_o, byte_valid, frame_done, err, locked}, 12'h000);
    model_reset();
    pend_v = 0;
    prev = 0;
    repeat (2) drive(0, 0);
    rst_n = 1'b1;
    obs_clear();
    send_frame(32'hFF003CA5, FB, SFD_V, -1, 0, 0, -1, 0, -1, 0);
    cmp("post_reset_nbytes", obs_bytes.size(), 4);
    for (int k = 0; k < 4 && k < obs_bytes.size(); k++)
      cmp($sformatf("post_reset_byte%0d", k), obs_bytes[k], tbl[0].exp_b[8*k +: 8]);
    cmp("post_reset_done", obs_done, 1);

    // Random frames with faults, slips, noise and valid gaps against the model
    for (int f = 0; f < 40; f++) begin
      logic [31:0] pay;
      int fb;
      pay = $urandom;
      fb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      send_frame(pay, FB, SFD_V, fb, $urandom_range(0, 7), $urandom_range(0, 1), -1, 1, -1, 1);
    end
    drive(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
